// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 core control path: FSM states, opcodes,
// and the ALUOp / ALUSrcB / PCSource select values that the datapath and ALU decoder agree on.
package core_ctrl_pkg;

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAddr  = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWrite = 4'd4;
  localparam logic [3:0] StMemWb    = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StAluWb    = 4'd7;
  localparam logic [3:0] StBranch   = 4'd8;
  localparam logic [3:0] StTrap     = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // Dispatch target out of DECODE; anything unsupported traps.
  function automatic logic [3:0] decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_next = StMemAddr;
      OP_RTYPE:          decode_next = StExecR;
      OP_BRANCH:         decode_next = StBranch;
      default:           decode_next = StTrap;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32 core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write strobe, plus the retire counter and sticky trap flag.
module multicycle_main_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32,
  parameter bit          WAIT_MEM  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 PCSource,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] InstretOne = INSTRET_W'(1);

  logic [3:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 illegal_op_q;
  logic                 retire;
  logic                 ready;

  // The branch compare is applied outside, via PCWriteCond, so zero is not needed here.
  logic unused_zero;
  assign unused_zero = zero;

  assign ready = WAIT_MEM ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode:   state_d = decode_next(opcode);
      StMemAddr:  state_d = (opcode == OP_STORE) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWrite: begin
        if (ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StMemWb, StAluWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExecR:    state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = ready;
        PCWrite = ready;
      end
      StDecode:   ALUSrcB = SRCB_IMM;
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      StAluWb:    RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      default: ;
    endcase
    // An abandoned instruction must not commit anything in the reset cycle.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      instret_q    <= '0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + InstretOne;
      if (state_d == StTrap) illegal_op_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_op_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: a default instance plus a 4-bit-counter,
// no-wait-memory instance driven from the same inputs.
module tb_multicycle_main_control;
  import core_ctrl_pkg::*;

  // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,
  // ALUSrcB[1:0],ALUOp[1:0],PCSource
  localparam logic [13:0] C_FETCH    = 14'b100101000_01_00_0;
  localparam logic [13:0] C_FETCH_W  = 14'b000100000_01_00_0;
  localparam logic [13:0] C_DECODE   = 14'b000000000_10_00_0;
  localparam logic [13:0] C_MEM_ADDR = 14'b000000001_10_00_0;
  localparam logic [13:0] C_MEM_READ = 14'b001100000_00_00_0;
  localparam logic [13:0] C_MEM_WR   = 14'b001010000_00_00_0;
  localparam logic [13:0] C_MEM_WB   = 14'b000000110_00_00_0;
  localparam logic [13:0] C_EXEC_R   = 14'b000000001_00_10_0;
  localparam logic [13:0] C_ALU_WB   = 14'b000000010_00_00_0;
  localparam logic [13:0] C_BRANCH   = 14'b010000001_00_01_1;
  localparam logic [13:0] C_NONE     = 14'b000000000_00_00_0;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [6:0] opcode;

  logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rgw, srca, pcsrc, ill;
  logic [1:0] srcb, aluop;
  logic [31:0] instret;
  logic pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rgw_b, srca_b, pcsrc_b, ill_b;
  logic [1:0] srcb_b, aluop_b;
  logic [3:0] instret_b;

  logic [13:0] ctl, ctl_b;
  logic [5:0]  strobes;
  assign ctl     = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rgw, srca, srcb, aluop, pcsrc};
  assign ctl_b   = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rgw_b, srca_b, srcb_b,
                    aluop_b, pcsrc_b};
  assign strobes = {pcw, pcwc, mrd, mwr, irw, rgw};

  int checks = 0;
  int fails  = 0;
  int unsigned n_ret = 0;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
    .IRWrite(irw), .MemtoReg(m2r), .RegWrite(rgw), .ALUSrcA(srca), .ALUSrcB(srcb),
    .ALUOp(aluop), .PCSource(pcsrc), .illegal_op(ill), .instret(instret)
  );

  multicycle_main_control #(.INSTRET_W(4), .WAIT_MEM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b), .MemWrite(mwr_b),
    .IRWrite(irw_b), .MemtoReg(m2r_b), .RegWrite(rgw_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b),
    .ALUOp(aluop_b), .PCSource(pcsrc_b), .illegal_op(ill_b), .instret(instret_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_ret = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; opcode = OP_LOAD; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (strobes !== 6'b0) begin
        $display("FAIL reset_strobes cyc%0d: got %b want 000000", i, strobes); fails++;
      end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FETCH) begin $display("FAIL reset_fetch: got %b want %b", ctl, C_FETCH); fails++; end
    checks++;
    if (instret !== 32'd0 || ill !== 1'b0) begin
      $display("FAIL reset_regs: got instret=%0d ill=%b want 0 0", instret, ill); fails++;
    end
  endtask

  task automatic test_lw;
    logic [13:0] exp [5];
    exp = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_READ, C_MEM_WB};
    opcode = OP_LOAD; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ctl !== exp[i]) begin $display("FAIL lw_cyc%0d: got %b want %b", i, ctl, exp[i]); fails++; end
      tick();
    end
    n_ret++;
    #1;
    checks++;
    if (instret !== n_ret) begin $display("FAIL lw_instret: got %0d want %0d", instret, n_ret); fails++; end
  endtask

  task automatic test_sw_wait;
    logic [13:0] exp [7];
    logic        rdy [7];
    exp = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_WR, C_MEM_WR, C_MEM_WR, C_MEM_WR};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = OP_STORE;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== exp[i]) begin $display("FAIL sw_cyc%0d: got %b want %b", i, ctl, exp[i]); fails++; end
      tick();
    end
    n_ret++;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FETCH || instret !== n_ret) begin
      $display("FAIL sw_done: got ctl=%b instret=%0d want %b %0d", ctl, instret, C_FETCH, n_ret);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] exp [7];
    logic [6:0]  ops [7];
    int unsigned ret [7];
    exp = '{C_FETCH, C_DECODE, C_EXEC_R, C_ALU_WB, C_FETCH, C_DECODE, C_BRANCH};
    ops = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_BRANCH, OP_BRANCH, OP_BRANCH};
    ret = '{n_ret, n_ret, n_ret, n_ret, n_ret + 1, n_ret + 1, n_ret + 1};
    mem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      #1;
      checks++;
      if (ctl !== exp[i] || instret !== ret[i]) begin
        $display("FAIL r_beq_cyc%0d: got ctl=%b instret=%0d want %b %0d", i, ctl, instret, exp[i],
                 ret[i]);
        fails++;
      end
      tick();
    end
    n_ret += 2;
    zero = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FETCH || instret !== n_ret) begin
      $display("FAIL r_beq_done: got ctl=%b instret=%0d want %b %0d", ctl, instret, C_FETCH, n_ret);
      fails++;
    end
  endtask

  task automatic test_trap;
    opcode = 7'b0010011; mem_ready = 1'b1;
    tick();
    tick();
    opcode = OP_LOAD;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (ctl !== C_NONE || ill !== 1'b1 || instret !== n_ret) begin
        $display("FAIL trap_cyc%0d: got ctl=%b ill=%b instret=%0d want %b 1 %0d", i, ctl, ill,
                 instret, C_NONE, n_ret);
        fails++;
      end
      tick();
    end
    pulse_reset();
    #1;
    checks++;
    if (ill !== 1'b0 || ctl !== C_FETCH || instret !== 32'd0) begin
      $display("FAIL trap_clear: got ill=%b ctl=%b instret=%0d want 0 %b 0", ill, ctl, instret,
               C_FETCH);
      fails++;
    end
  endtask

  task automatic test_no_wait;
    logic [13:0] exp [4];
    exp = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_WR};
    pulse_reset();
    opcode = OP_STORE; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl_b !== exp[i] || ctl !== C_FETCH_W) begin
        $display("FAIL nowait_cyc%0d: got b=%b a=%b want %b %b", i, ctl_b, ctl, exp[i], C_FETCH_W);
        fails++;
      end
      tick();
    end
    #1;
    checks++;
    if (instret_b !== 4'd1 || instret !== 32'd0) begin
      $display("FAIL nowait_instret: got b=%0d a=%0d want 1 0", instret_b, instret); fails++;
    end
  endtask

  task automatic test_wrap;
    logic [3:0] want;
    pulse_reset();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      repeat (4) tick();
      want = 4'(k);
      #1;
      checks++;
      if (instret_b !== want) begin
        $display("FAIL wrap_k%0d: got %0d want %0d", k, instret_b, want); fails++;
      end
    end
    n_ret = 16;
    checks++;
    if (instret !== n_ret) begin $display("FAIL wrap_wide: got %0d want %0d", instret, n_ret); fails++; end
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    opcode = OP_LOAD; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_MEM_READ) begin $display("FAIL mid_memread: got %b want %b", ctl, C_MEM_READ); fails++; end
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (strobes !== 6'b0) begin $display("FAIL mid_reset_strobes: got %b want 000000", strobes); fails++; end
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_FETCH_W || rgw !== 1'b0 || instret !== 32'd0) begin
        $display("FAIL mid_after_cyc%0d: got ctl=%b instret=%0d want %b 0", i, ctl, instret,
                 C_FETCH_W);
        fails++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_trap();
    test_no_wait();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
